// File: rtl/vlsu_pkg.sv
// Shared types and bus geometry for the vector-load sequencing path.
// Bus widths are fixed here because the record/burst structs are built from them.
package vlsu_pkg;

    localparam int unsigned AxiDataWidth  = 128;
    localparam int unsigned AxiAddrWidth  = 64;
    localparam int unsigned BusBytes      = AxiDataWidth / 8;
    localparam int unsigned BusNibbles    = AxiDataWidth / 4;
    localparam int unsigned BusNSize      = $clog2(BusNibbles);
    localparam int unsigned BusOffWidth   = $clog2(BusBytes);
    // lbN ranges 1..BusNibbles inclusive, so it needs one bit more than BusNSize
    localparam int unsigned LbnWidth      = BusNSize + 1;

    localparam int unsigned BurstBoundary  = 4096;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } seq_state_e;

    typedef struct packed {
        logic [AxiAddrWidth:0]   addr;        // nibble address of the burst start
        logic                    isHead;
        logic [7:0]              rmnBeat;
        logic [LbnWidth-1:0]     lbN;
        logic                    isFinalTxn;
    } txn_ctrl_t;

    // 'final' is a reserved word, hence is_final
    typedef struct packed {
        logic [AxiAddrWidth-1:0] addr;
        logic [8:0]              beats;
        logic [LbnWidth-1:0]     lbN;
        logic                    is_final;
    } ar_burst_info_t;

endpackage

// File: rtl/burst_info_fifo.sv
// In-order queue of issued AR bursts awaiting per-beat record emission.
// Pushes are refused while full and pops while empty.
module burst_info_fifo
    import vlsu_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           i_push,
    input  ar_burst_info_t i_data,
    input  logic           i_pop,
    output ar_burst_info_t o_data,
    output logic           o_full,
    output logic           o_empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    ar_burst_info_t  r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CntW'(Depth));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately left unreset; the pointers and count decide
    // what is valid, and a reset on the array would only cost flops.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/load_txn_sequencer.sv
// Splits one contiguous load request into 4 KiB-safe AXI INCR bursts and emits
// one control record per expected R beat, in burst order.
module load_txn_sequencer
    import vlsu_pkg::*;
#(
    parameter int unsigned LenWidth    = 32,
    parameter int unsigned MaxBurstLen = 256,
    parameter int unsigned TxnQDepth   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AxiAddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]     req_len_i,

    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [AxiAddrWidth-1:0] ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [1:0]              ar_burst_o,

    output logic                    txn_ctrl_valid_o,
    input  logic                    txn_ctrl_ready_i,
    output txn_ctrl_t               txn_ctrl_o,

    output logic                    busy_o
);

    localparam int unsigned CalcW         = LenWidth + 1;
    localparam int unsigned MaxBurstBytes = MaxBurstLen * BusBytes;

    seq_state_e              r_state;
    seq_state_e              w_state_nxt;
    logic [AxiAddrWidth-1:0] r_cur_addr;
    logic [LenWidth-1:0]     r_rmn_bytes;
    logic [7:0]              r_bcnt;

    logic                    w_issue;
    logic                    w_req_hs;
    logic                    w_ar_hs;
    logic                    w_txn_hs;
    logic [BusOffWidth-1:0]  w_off;
    logic [12:0]             w_to_4k;
    logic [CalcW-1:0]        w_to_max;
    logic [CalcW-1:0]        w_bytes;
    logic [CalcW-1:0]        w_span;
    logic [CalcW-1:0]        w_end;
    logic [8:0]              w_beats;
    logic [LbnWidth-1:0]     w_lbn;
    logic                    w_final;

    ar_burst_info_t          w_push_data;
    ar_burst_info_t          w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic [7:0]              w_rmn_beat;

    // Burst geometry depends only on registers, so it is stable while AR stalls
    assign w_off    = r_cur_addr[BusOffWidth-1:0];
    assign w_to_4k  = 13'(BurstBoundary) - {1'b0, r_cur_addr[11:0]};
    assign w_to_max = CalcW'(MaxBurstBytes) - CalcW'(w_off);

    always_comb begin
        w_bytes = {1'b0, r_rmn_bytes};
        if (CalcW'(w_to_4k) < w_bytes) w_bytes = CalcW'(w_to_4k);
        if (w_to_max < w_bytes)        w_bytes = w_to_max;
    end

    assign w_span  = CalcW'(w_off) + w_bytes + CalcW'(BusBytes - 1);
    assign w_beats = 9'(w_span >> BusOffWidth);
    assign w_end   = CalcW'(w_off) + w_bytes - CalcW'(1);
    assign w_lbn   = ({{(LbnWidth - BusOffWidth){1'b0}}, w_end[BusOffWidth-1:0]}
                      + LbnWidth'(1)) << 1;
    assign w_final = (w_bytes == {1'b0, r_rmn_bytes});

    assign w_issue    = (r_state == S_ISSUE);
    assign ar_valid_o = w_issue && !w_full;
    assign w_ar_hs    = ar_valid_o && ar_ready_i;
    assign w_req_hs   = req_valid_i && req_ready_o;
    assign ar_addr_o  = w_issue ? r_cur_addr : '0;
    assign ar_len_o   = w_issue ? 8'(w_beats - 9'd1) : '0;
    assign ar_size_o  = 3'(BusOffWidth);
    assign ar_burst_o = AXI_BURST_INCR;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i && (req_len_i != '0)) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_ar_hs && w_final) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cur_addr  <= '0;
            r_rmn_bytes <= '0;
        end else if (w_req_hs) begin
            r_cur_addr  <= req_addr_i;
            r_rmn_bytes <= req_len_i;
        end else if (w_ar_hs) begin
            r_cur_addr  <= r_cur_addr + AxiAddrWidth'(w_bytes);
            r_rmn_bytes <= r_rmn_bytes - LenWidth'(w_bytes);
        end
    end

    assign w_push_data = '{addr: r_cur_addr, beats: w_beats, lbN: w_lbn, is_final: w_final};

    burst_info_fifo #(
        .Depth (TxnQDepth)
    ) u_burst_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_ar_hs),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign txn_ctrl_valid_o = !w_empty;
    assign w_txn_hs         = txn_ctrl_valid_o && txn_ctrl_ready_i;
    assign w_rmn_beat       = 8'(w_head.beats - 9'd1 - {1'b0, r_bcnt});
    assign w_pop            = w_txn_hs && (w_rmn_beat == 8'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bcnt <= '0;
        end else if (w_txn_hs) begin
            r_bcnt <= (w_rmn_beat == 8'd0) ? 8'd0 : r_bcnt + 8'd1;
        end
    end

    // Unwritten FIFO slots may hold anything, so the record is zeroed when idle
    always_comb begin
        txn_ctrl_o = '0;
        if (!w_empty) begin
            txn_ctrl_o.addr       = {w_head.addr, 1'b0};
            txn_ctrl_o.isHead     = (r_bcnt == 8'd0);
            txn_ctrl_o.rmnBeat    = w_rmn_beat;
            txn_ctrl_o.lbN        = w_head.lbN;
            txn_ctrl_o.isFinalTxn = w_head.is_final;
        end
    end

    assign busy_o = w_issue || !w_empty;

endmodule

// File: tb/tb_load_txn_sequencer.sv
// Directed and randomized checks of load_txn_sequencer against a burst-splitting
// reference model computed from address/length arithmetic.
module tb_load_txn_sequencer;
    import vlsu_pkg::*;

    localparam int unsigned MBL = 16;
    localparam int unsigned QD  = 2;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [AxiAddrWidth-1:0] req_addr_i;
    logic [31:0]             req_len_i;
    logic                    ar_valid_o;
    logic                    ar_ready_i;
    logic [AxiAddrWidth-1:0] ar_addr_o;
    logic [7:0]              ar_len_o;
    logic [2:0]              ar_size_o;
    logic [1:0]              ar_burst_o;
    logic                    txn_ctrl_valid_o;
    logic                    txn_ctrl_ready_i;
    txn_ctrl_t               txn_ctrl_o;
    logic                    busy_o;

    load_txn_sequencer #(
        .LenWidth    (32),
        .MaxBurstLen (MBL),
        .TxnQDepth   (QD)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_len_i        (req_len_i),
        .ar_valid_o       (ar_valid_o),
        .ar_ready_i       (ar_ready_i),
        .ar_addr_o        (ar_addr_o),
        .ar_len_o         (ar_len_o),
        .ar_size_o        (ar_size_o),
        .ar_burst_o       (ar_burst_o),
        .txn_ctrl_valid_o (txn_ctrl_valid_o),
        .txn_ctrl_ready_i (txn_ctrl_ready_i),
        .txn_ctrl_o       (txn_ctrl_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int n_ar     = 0;
    int n_rec    = 0;
    int ar_stall = 0;
    int tx_stall = 0;
    bit txn_hold = 1'b0;
    bit rec_popped;

    logic [63:0]  pend_addr [$];
    logic [31:0]  pend_len  [$];
    logic [71:0]  exp_ar    [$];
    txn_ctrl_t    exp_rec   [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the request greedily, each burst limited by what is left,
    // by the next 4 KiB page and by MBL bus beats measured from the aligned base.
    function automatic void model_req(input logic [63:0] a, input logic [31:0] len);
        longint unsigned addr, rem, off, b, to_page, cap;
        int              beats;
        txn_ctrl_t       r;
        addr = a;
        rem  = len;
        while (rem > 0) begin
            off     = addr % BusBytes;
            to_page = 4096 - (addr % 4096);
            cap     = MBL * BusBytes - off;
            b       = rem;
            if (to_page < b) b = to_page;
            if (cap < b)     b = cap;
            beats = int'((off + b + BusBytes - 1) / BusBytes);
            exp_ar.push_back({64'(addr), 8'(beats - 1)});
            for (int k = 0; k < beats; k++) begin
                r.addr       = {64'(addr), 1'b0};
                r.isHead     = (k == 0);
                r.rmnBeat    = 8'(beats - 1 - k);
                r.lbN        = LbnWidth'((((addr + b - 1) % BusBytes) + 1) * 2);
                r.isFinalTxn = (b == rem);
                exp_rec.push_back(r);
            end
            addr += b;
            rem  -= b;
        end
    endfunction

    // One cycle: drive inputs at the falling edge, compare every visible output
    // against the head of the expected queues, and retire what handshakes.
    task automatic step();
        @(negedge clk_i);
        req_valid_i = 1'b0;
        if (pend_addr.size() != 0 && req_ready_o) begin
            req_valid_i = 1'b1;
            req_addr_i  = pend_addr.pop_front();
            req_len_i   = pend_len.pop_front();
            model_req(req_addr_i, req_len_i);
        end
        ar_ready_i       = ($urandom_range(0, 99) >= ar_stall);
        txn_ctrl_ready_i = txn_hold ? 1'b0 : ($urandom_range(0, 99) >= tx_stall);
        rec_popped       = 1'b0;
        if (ar_valid_o) begin
            chk("ar_expected", exp_ar.size() != 0, 1'b1);
            if (exp_ar.size() != 0) begin
                chk("ar_fields", {ar_addr_o, ar_len_o}, exp_ar[0]);
                if (ar_ready_i) begin
                    void'(exp_ar.pop_front());
                    n_ar++;
                end
            end
        end
        if (txn_ctrl_valid_o) begin
            chk("rec_expected", exp_rec.size() != 0, 1'b1);
            if (exp_rec.size() != 0) begin
                chk("rec_fields", txn_ctrl_o, exp_rec[0]);
                if (txn_ctrl_ready_i) begin
                    rec_popped = (exp_rec[0].rmnBeat == 8'd0);
                    void'(exp_rec.pop_front());
                    n_rec++;
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((pend_addr.size() != 0 || exp_ar.size() != 0 || exp_rec.size() != 0)
               && c < budget) begin
            step();
            c++;
        end
        chk("drain_in_budget", c < budget, 1'b1);
        step();
        chk("idle_busy", busy_o, 1'b0);
        chk("idle_req_ready", req_ready_o, 1'b1);
    endtask

    task automatic add_req(input logic [63:0] a, input logic [31:0] len);
        pend_addr.push_back(a);
        pend_len.push_back(len);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready_o, 1'b1);
        chk({tag, "_ar_valid"},  ar_valid_o, 1'b0);
        chk({tag, "_txn_valid"}, txn_ctrl_valid_o, 1'b0);
        chk({tag, "_busy"},      busy_o, 1'b0);
        chk({tag, "_ar_addr"},   ar_addr_o, '0);
        chk({tag, "_ar_len"},    ar_len_o, '0);
        chk({tag, "_txn_ctrl"},  txn_ctrl_o, '0);
        chk({tag, "_ar_size"},   ar_size_o, 3'd4);
        chk({tag, "_ar_burst"},  ar_burst_o, 2'b01);
    endtask

    initial begin
        int base_ar;
        int base_rec;
        int c;
        logic [63:0] ra;

        rst_ni           = 1'b0;
        req_valid_i      = 1'b0;
        req_addr_i       = '0;
        req_len_i        = '0;
        ar_ready_i       = 1'b0;
        txn_ctrl_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("rst");
        rst_ni = 1'b1;

        // Single burst with unaligned start; AR one cycle after request, record one after AR
        add_req(64'h1004, 32'd40);
        base_ar  = n_ar;
        base_rec = n_rec;
        step();
        step();
        chk("ar_latency", ar_valid_o, 1'b1);
        chk("issue_busy", busy_o, 1'b1);
        chk("issue_req_ready", req_ready_o, 1'b0);
        chk("ar_fields_0x1004", {ar_addr_o, ar_len_o}, {64'h1004, 8'd2});
        step();
        chk("rec_latency", txn_ctrl_valid_o, 1'b1);
        drain(200);
        chk("n_ar_0x1004", n_ar - base_ar, 1);
        chk("n_rec_0x1004", n_rec - base_rec, 3);

        // Crossing a 4 KiB page splits into two single-beat bursts
        base_ar = n_ar;
        add_req(64'h0FF8, 32'd16);
        drain(200);
        chk("n_ar_4k_split", n_ar - base_ar, 2);

        // Maximum burst length split
        base_ar  = n_ar;
        base_rec = n_rec;
        add_req(64'h0, 32'd512);
        drain(400);
        chk("n_ar_maxlen", n_ar - base_ar, 2);
        chk("n_rec_maxlen", n_rec - base_rec, 32);

        // Zero length: nothing happens
        add_req(64'h2000, 32'd0);
        step();
        repeat (3) begin
            step();
            chk("len0_req_ready", req_ready_o, 1'b1);
            chk("len0_busy", busy_o, 1'b0);
        end

        // Full burst FIFO blocks AR until a pop, then issue resumes one cycle later
        base_ar  = n_ar;
        txn_hold = 1'b1;
        add_req(64'h0, 32'd1024);
        repeat (12) step();
        chk("full_ar_count", n_ar - base_ar, QD);
        chk("full_ar_valid", ar_valid_o, 1'b0);
        txn_hold = 1'b0;
        c = 0;
        do begin
            step();
            c++;
        end while (!rec_popped && c < 64);
        chk("first_pop_seen", rec_popped, 1'b1);
        chk("full_until_pop", ar_valid_o, 1'b0);
        step();
        chk("resume_after_pop", ar_valid_o, 1'b1);
        drain(400);

        // Reset mid-request with two bursts queued
        base_ar  = n_ar;
        txn_hold = 1'b1;
        add_req(64'h5000, 32'd1024);
        c = 0;
        while ((n_ar - base_ar) < 2 && c < 40) begin
            step();
            c++;
        end
        chk("pre_reset_queued", n_ar - base_ar, 2);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_ar.delete();
        exp_rec.delete();
        pend_addr.delete();
        pend_len.delete();
        txn_hold = 1'b0;
        req_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        add_req(64'h3010, 32'd100);
        drain(200);

        // Randomized requests with stalls on both sides, back-to-back
        ar_stall = 30;
        tx_stall = 30;
        for (int i = 0; i < 30; i++) begin
            ra = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
            add_req(ra, ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 1500)));
        end
        drain(40000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
